// File: rtl/serial_deframer_pkg.sv
// rtl/serial_deframer_pkg.sv - shared types, defaults and parity helper for serial_deframer
// Contents: deframer_state_e FSM encoding, default parameter values, parity_f even-parity helper.
package serial_deframer_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } deframer_state_e;

  localparam int                    DEF_SYNC_W      = 3;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT    = 3'b111;
  localparam int                    DEF_DATA_W      = 8;
  localparam int                    DEF_FRAME_WORDS = 2;

  // Widest word parity_f accepts; narrower words are zero-extended by the caller.
  localparam int PARITY_MAX_W = 64;

  // Even-parity bit: the value that makes the total count of ones even.
  function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_deframer_word_fifo2.sv
// rtl/serial_deframer_word_fifo2.sv - 2-entry synchronous FIFO (word_fifo2) used as a skid buffer
// Ports: clk, rst (sync, active-high); push/data_in/full write side; pop/data_out/empty read side.
// A push while full is accepted only when a pop happens in the same cycle.
module word_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data_in,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] data_out,
  output logic         empty
);

  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign data_out = d0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // d0 is always the head; entries shift forward on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0    <= '0;
      d1    <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            d0 <= data_in;
          end else begin
            d0 <= d1;
            d1 <= data_in;
          end
        end
        2'b10: begin
          if (count == 2'd0) d0 <= data_in;
          else               d1 <= data_in;
          count <= count + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// rtl/serial_deframer.sv - sync-hunting serial deframer delivering MSB-first words over valid/ready
// Ports: clk, rst (sync, active-high); in/in_vld serial bit input; out_data/out_vld/out_rdy word output;
// frame_done pulse after the last word of a frame; ovf sticky drop flag;
// par_err pulse on parity mismatch (only when SERIAL_DEFRAMER_PARITY_EN is defined).
// Macro SERIAL_DEFRAMER_PARITY_EN: each word is followed by an even-parity bit checked in PAR.
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int                SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT    = DEF_SYNC_PAT,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              in_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              frame_done,
`ifdef SERIAL_DEFRAMER_PARITY_EN
  output logic              par_err,
`endif
  output logic              ovf
);

  localparam int BW = $clog2(DATA_W + 1);

  deframer_state_e   state, state_n;
  logic [SYNC_W-1:0] sync_sr, sync_sr_n;
  logic [DATA_W-1:0] word, word_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [7:0]        word_cnt, word_cnt_n;
  logic              frame_done_n;
  logic              push;
  logic              word_end;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic              par_err_n;
`endif

  assign out_vld = !fifo_empty;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      sync_sr    <= '0;
      word       <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sync_sr    <= sync_sr_n;
      word       <= word_n;
      bit_cnt    <= bit_cnt_n;
      word_cnt   <= word_cnt_n;
      frame_done <= frame_done_n;
      // The serial side cannot stall, so a word with nowhere to go is lost.
      ovf        <= ovf | (push && fifo_full && !pop);
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_err    <= par_err_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    sync_sr_n    = sync_sr;
    word_n       = word;
    bit_cnt_n    = bit_cnt;
    word_cnt_n   = word_cnt;
    frame_done_n = 1'b0;
    push         = 1'b0;
    word_end     = 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    par_err_n    = 1'b0;
`endif
    case (state)
      HUNT: begin
        if (in_vld) begin
          sync_sr_n = {sync_sr[SYNC_W-2:0], in};
          if (sync_sr_n == SYNC_PAT) begin
            state_n    = DATA;
            sync_sr_n  = '0;
            bit_cnt_n  = '0;
            word_cnt_n = '0;
          end
        end
      end
      DATA: begin
        if (in_vld) begin
          word_n    = {word[DATA_W-2:0], in};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_cnt_n = '0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            state_n   = PAR;
`else
            push      = 1'b1;
            word_end  = 1'b1;
`endif
          end
        end
      end
`ifdef SERIAL_DEFRAMER_PARITY_EN
      PAR: begin
        if (in_vld) begin
          // A rejected word still occupies a frame slot.
          word_end = 1'b1;
          if (parity_f(PARITY_MAX_W'(word)) == in) push = 1'b1;
          else                                     par_err_n = 1'b1;
        end
      end
`endif
      default: state_n = HUNT;
    endcase

    if (word_end) begin
      if (word_cnt == 8'(FRAME_WORDS - 1)) begin
        frame_done_n = 1'b1;
        state_n      = HUNT;
        word_cnt_n   = '0;
      end else begin
        word_cnt_n = word_cnt + 8'd1;
        state_n    = DATA;
      end
    end
  end

  // word_n equals word in PAR, so it is the pushed word in both configurations.
  word_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .data_in  (word_n),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (out_data),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_serial_deframer.sv
// tb/tb_serial_deframer.sv - self-checking bench for serial_deframer with a bit-stream reference model
module tb_serial_deframer;

  logic       clk;
  logic       rst;
  logic       in;
  logic       in_vld;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       frame_done;
  logic       ovf;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic       par_err;
  localparam int WORD_BITS = 9;
`else
  localparam int WORD_BITS = 8;
`endif

  serial_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_vld     (in_vld),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .frame_done (frame_done),
`ifdef SERIAL_DEFRAMER_PARITY_EN
    .par_err    (par_err),
`endif
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: parse accepted bits as a stream, then a 2-deep word queue.
  bit         m_hunt = 1;
  bit         hist[$];
  bit         bits[$];
  int         wcnt = 0;
  logic [7:0] mq[$];
  bit         m_ovf = 0;
  bit         m_fd = 0;
  bit         m_pe = 0;

  always @(posedge clk) begin : model
    bit         pop;
    bit         have;
    int         ones;
    logic [7:0] w;
    m_fd = 0;
    m_pe = 0;
    have = 0;
    w    = 8'h00;
    if (rst) begin
      mq.delete(); hist.delete(); bits.delete();
      m_ovf = 0; m_hunt = 1; wcnt = 0;
    end else begin
      pop = (mq.size() > 0) && out_rdy;
      if (in_vld) begin
        if (m_hunt) begin
          hist.push_back(in);
          if (hist.size() > 3) void'(hist.pop_front());
          if (hist.size() == 3 && hist[0] && hist[1] && hist[2]) begin
            m_hunt = 0; hist.delete(); bits.delete(); wcnt = 0;
          end
        end else begin
          bits.push_back(in);
          if (bits.size() == WORD_BITS) begin
            ones = 0;
            for (int i = 0; i < 8; i++) begin
              w = {w[6:0], bits[i]};
              ones += bits[i];
            end
            have = 1;
            if (WORD_BITS == 9 && ((ones + bits[8]) % 2) != 0) begin
              have = 0; m_pe = 1;
            end
            bits.delete();
            wcnt++;
            if (wcnt == 2) begin m_fd = 1; m_hunt = 1; wcnt = 0; end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < 2) mq.push_back(w);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison plus logging of consumed words and pulses.
  logic [7:0] got[$];
  int         fd_cnt = 0;
  int         pe_cnt = 0;
  logic       fd_vld = 0;
  logic [7:0] fd_data = 0;

  always @(negedge clk) begin
    if (run_chk) begin
      chk("out_vld", out_vld, mq.size() > 0);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("frame_done", frame_done, m_fd);
      chk("ovf", ovf, m_ovf);
`ifdef SERIAL_DEFRAMER_PARITY_EN
      chk("par_err", par_err, m_pe);
      if (par_err) pe_cnt++;
`endif
      if (out_vld && out_rdy) got.push_back(out_data);
      if (frame_done) begin fd_cnt++; fd_vld = out_vld; fd_data = out_data; end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input bit b, input int gapmax);
    int gap;
    gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (gap) begin
      in = 1'($urandom); in_vld = 0;
      @(posedge clk); #1;
    end
    in = b; in_vld = 1;
    @(posedge clk); #1;
    in_vld = 0;
  endtask

  task automatic send_sync(input int gapmax);
    repeat (3) send_bit(1'b1, gapmax);
  endtask

  task automatic send_word(input logic [7:0] w, input int gapmax, input bit rdy_last, input bit badpar);
    for (int i = 7; i >= 0; i--) begin
      if (rdy_last && WORD_BITS == 8 && i == 0) out_rdy = 1;
      send_bit(w[i], gapmax);
    end
`ifdef SERIAL_DEFRAMER_PARITY_EN
    if (rdy_last) out_rdy = 1;
    send_bit((^w) ^ badpar, gapmax);
`endif
  endtask

  task automatic check_got(input string name, input logic [31:0] e, input int n);
    chk({name, " count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk(name, got[i], e[31-8*i -: 8]);
    got.delete();
  endtask

  task automatic do_reset();
    rst = 1; in_vld = 0;
    @(posedge clk); #1;
    run_chk = 1;
    chk("rst out_vld", out_vld, 0);
    chk("rst out_data", out_data, 0);
    chk("rst ovf", ovf, 0);
    chk("rst frame_done", frame_done, 0);
    rst = 0;
    idle(1);
    chk("post rst out_vld", out_vld, 0);
    got.delete(); fd_cnt = 0; pe_cnt = 0; fd_vld = 0; fd_data = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; in = 0; in_vld = 0; out_rdy = 1;
    do_reset();

    // Basic frame, continuous bits.
    send_sync(0);
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0);
    idle(4);
    check_got("t1 words", 32'hA53C_0000, 2);
    chk("t1 fd count", fd_cnt, 1);
    chk("t1 fd with last", {fd_vld, fd_data}, {1'b1, 8'h3C});
    chk("t1 ovf", ovf, 0);

    // Noise before sync and random in_vld gaps.
    fd_cnt = 0;
    send_bit(0, 2); send_bit(1, 2); send_bit(0, 2);
    send_bit(1, 2); send_bit(1, 2);
    chk("t2 no early word", out_vld, 0);
    send_bit(1, 2);
    send_word(8'hA5, 3, 0, 0);
    send_word(8'h3C, 3, 0, 0);
    idle(4);
    check_got("t2 words", 32'hA53C_0000, 2);
    chk("t2 fd count", fd_cnt, 1);

    // Consumer stalled: third word dropped, ovf sticky.
    out_rdy = 0;
    send_sync(0);
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0);
    chk("t3 ovf before drop", ovf, 0);
    send_sync(0);
    send_word(8'h5A, 0, 0, 0);
    chk("t3 ovf after drop", ovf, 1);
    send_word(8'hC3, 0, 0, 0);
    idle(5);
    chk("t3 ovf held", ovf, 1);
    chk("t3 head held", out_data, 8'hA5);
    out_rdy = 1;
    idle(4);
    check_got("t3 words", 32'hA53C_0000, 2);
    chk("t3 ovf still set", ovf, 1);
    do_reset();
    chk("t3 ovf cleared", ovf, 0);

    // Full buffer with a pop in the completion cycle: no drop.
    out_rdy = 0;
    send_sync(0);
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0);
    send_sync(0);
    send_word(8'h5A, 0, 1, 0);
    send_word(8'hC3, 0, 0, 0);
    idle(5);
    check_got("t4 words", 32'hA53C_5AC3, 4);
    chk("t4 ovf", ovf, 0);

    // Reset mid-frame flushes buffered words.
    out_rdy = 0;
    send_sync(0);
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0);
    send_sync(0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    do_reset();
    out_rdy = 1;
    send_sync(0);
    send_word(8'h11, 0, 0, 0);
    send_word(8'h22, 0, 0, 0);
    idle(4);
    check_got("t5 words", 32'h1122_0000, 2);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    // Bad parity drops the word but it still counts toward the frame.
    fd_cnt = 0;
    send_sync(0);
    send_word(8'hA5, 0, 0, 1);
    send_word(8'h3C, 0, 0, 0);
    idle(4);
    check_got("t6 bad parity words", 32'h3C00_0000, 1);
    chk("t6 par_err count", pe_cnt, 1);
    chk("t6 fd count", fd_cnt, 1);
    send_sync(0);
    send_word(8'hA5, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0);
    idle(4);
    check_got("t6 good parity words", 32'hA53C_0000, 2);
    chk("t6 par_err total", pe_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
